// File: rtl/snif_evt_sched_pkg.sv
// snif_evt_sched_pkg: shared state encoding and defaults for the doorbell event scheduler
package snif_evt_sched_pkg;
  typedef enum logic {SES_IDLE = 1'b0, SES_OFFER = 1'b1} ses_state_e;
  localparam int SNIF_NUM_CH = 4;
endpackage

// File: rtl/snif_evt_sched_rr_arb.sv
// snif_rr_arb: combinational round-robin pick of the first request after the last grant
module snif_rr_arb #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] last_i,
  output logic [$clog2(N)-1:0] gnt_o,
  output logic                 any_o
);
  localparam int CW = $clog2(N);
  always_comb begin
    gnt_o = '0;
    any_o = |req_i;
    // Walk from farthest to nearest so the nearest request after last_i wins
    for (int i = N; i > 0; i--)
      if (req_i[last_i + CW'(i)]) gnt_o = last_i + CW'(i);
  end
endmodule

// File: rtl/snif_evt_sched.sv
// snif_evt_sched: captures doorbell-window writes as per-channel events and offers them round-robin
module snif_evt_sched
  import snif_evt_sched_pkg::*;
#(
  parameter int ADR_WIDTH = 6,
  parameter int DAT_WIDTH = 8,
  parameter int NUM_CH    = SNIF_NUM_CH
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [ADR_WIDTH-1:0]      adr_i,
  input  logic [DAT_WIDTH-1:0]      dat_i,
  input  logic                      we_i,
  input  logic                      arm_i,
  output logic                      evt_valid_o,
  input  logic                      evt_ready_i,
  output logic [$clog2(NUM_CH)-1:0] evt_ch_o,
  output logic [DAT_WIDTH-1:0]      evt_dat_o,
  output logic [NUM_CH-1:0]         pending_o,
  output logic [NUM_CH-1:0]         ovf_o,
  input  logic                      ovf_clr_i
);
  localparam int CW = $clog2(NUM_CH);
  ses_state_e state_q, state_d;
  logic [NUM_CH-1:0] pend_q, pend_d, ovf_q, ovf_d, hit_v, clr_v;
  logic [NUM_CH-1:0][DAT_WIDTH-1:0] data_q, data_d;
  logic [CW-1:0] rr_q, rr_d, ch_q, ch_d, gnt;
  logic [DAT_WIDTH-1:0] dat_q, dat_d;
  logic hit, hs, any;
  // Window is the top NUM_CH addresses: every bit above the channel field is set
  assign hit   = we_i & arm_i & ((adr_i | ADR_WIDTH'(NUM_CH - 1)) == '1);
  assign hs    = (state_q == SES_OFFER) & evt_ready_i;
  assign hit_v = hit ? NUM_CH'(1) << adr_i[CW-1:0] : '0;
  assign clr_v = hs ? NUM_CH'(1) << ch_q : '0;
  snif_rr_arb #(.N(NUM_CH)) u_arb (
    .req_i  (pend_q),
    .last_i (rr_q),
    .gnt_o  (gnt),
    .any_o  (any)
  );
  always_comb begin
    pend_d = hit_v | (pend_q & ~clr_v);
    ovf_d  = (hit_v & pend_q & ~clr_v) | (ovf_q & {NUM_CH{~ovf_clr_i}});
    for (int c = 0; c < NUM_CH; c++)
      data_d[c] = (hit_v[c] & ~(pend_q[c] & ~clr_v[c])) ? dat_i : data_q[c];
    state_d = state_q;
    ch_d    = ch_q;
    dat_d   = dat_q;
    rr_d    = rr_q;
    if (state_q == SES_IDLE) begin
      if (any) begin
        state_d = SES_OFFER;
        ch_d    = gnt;
        dat_d   = data_q[gnt];
      end
    end else if (evt_ready_i) begin
      state_d = SES_IDLE;
      rr_d    = ch_q;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= SES_IDLE;
      pend_q  <= '0;
      ovf_q   <= '0;
      data_q  <= '0;
      ch_q    <= '0;
      dat_q   <= '0;
      rr_q    <= CW'(NUM_CH - 1);
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      dat_q   <= dat_d;
      rr_q    <= rr_d;
    end
  end
  assign evt_valid_o = (state_q == SES_OFFER);
  assign evt_ch_o    = ch_q;
  assign evt_dat_o   = dat_q;
  assign pending_o   = pend_q;
  assign ovf_o       = ovf_q;
endmodule

// File: tb/tb_snif_evt_sched.sv
// tb_snif_evt_sched: random and directed stimulus checked cycle by cycle against an event-level model
module tb_snif_evt_sched;
  logic       clk = 0;
  logic       rst_n, we, arm, ready, clr;
  logic [5:0] adr;
  logic [7:0] dat;
  logic       evt_valid;
  logic [1:0] evt_ch;
  logic [7:0] evt_dat;
  logic [3:0] pending, ovf;
  int checks = 0, errors = 0;
  logic [3:0] m_pend, m_ovf;
  logic [7:0] m_data [4];
  logic       m_valid;
  int         m_ch, m_rr;
  logic [7:0] m_dat;

  always #5 clk = ~clk;

  snif_evt_sched dut (
    .clk_i(clk), .rst_ni(rst_n), .adr_i(adr), .dat_i(dat), .we_i(we), .arm_i(arm),
    .evt_valid_o(evt_valid), .evt_ready_i(ready), .evt_ch_o(evt_ch), .evt_dat_o(evt_dat),
    .pending_o(pending), .ovf_o(ovf), .ovf_clr_i(clr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge of the intended behaviour, computed from the pre-edge state
  task automatic model();
    logic [3:0] old_p;
    logic hit, hs;
    int hc, old_ch;
    if (!rst_n) begin
      m_pend = 0; m_ovf = 0; m_valid = 0; m_ch = 0; m_dat = 0; m_rr = 3;
      return;
    end
    old_p  = m_pend;
    old_ch = m_ch;
    hit    = we && arm && adr >= 60;
    hc     = int'(adr) - 60;
    hs     = m_valid && ready;
    if (m_valid) begin
      if (ready) begin
        m_pend[m_ch] = 0;
        m_rr = m_ch;
        m_valid = 0;
      end
    end else if (old_p != 0) begin
      for (int i = 1; i <= 4; i++)
        if (old_p[(m_rr + i) % 4]) begin
          m_ch = (m_rr + i) % 4;
          break;
        end
      m_dat = m_data[m_ch];
      m_valid = 1;
    end
    if (clr) m_ovf = 0;
    if (hit) begin
      if (old_p[hc] && !(hs && old_ch == hc)) m_ovf[hc] = 1;
      else begin
        m_pend[hc] = 1;
        m_data[hc] = dat;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model();
    @(negedge clk);
    chk("valid", evt_valid, m_valid);
    chk("ch", evt_ch, m_ch);
    chk("dat", evt_dat, m_dat);
    chk("pending", pending, m_pend);
    chk("ovf", ovf, m_ovf);
  endtask

  task automatic wr(input logic [5:0] a, input logic [7:0] d);
    we = 1; adr = a; dat = d;
    step();
    we = 0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) m_data[i] = 0;
    rst_n = 0; we = 0; arm = 1; ready = 1; clr = 0; adr = 0; dat = 0;
    step(); step();
    chk("rst_pending", pending, 4'b0000);
    chk("rst_valid", evt_valid, 1'b0);
    rst_n = 1;
    for (int a = 0; a < 60; a++) wr(6'(a), 8'($urandom));
    chk("sweep_pending", pending, 4'b0000);
    wr(61, 8'hA5);
    chk("s2_pend", pending, 4'b0010);
    step();
    chk("s2_valid", evt_valid, 1'b1);
    chk("s2_ch", evt_ch, 2'd1);
    chk("s2_dat", evt_dat, 8'hA5);
    step();
    chk("s2_done_pend", pending, 4'b0000);
    chk("s2_done_valid", evt_valid, 1'b0);
    ready = 0;
    wr(60, 8'h01); wr(62, 8'h02); wr(63, 8'h03);
    repeat (5) step();
    ready = 1;
    repeat (8) step();
    ready = 0;
    wr(63, 8'h11); wr(63, 8'h22);
    step();
    chk("s4_ovf", ovf, 4'b1000);
    chk("s4_dat", evt_dat, 8'h11);
    clr = 1; step(); clr = 0;
    chk("s4_clr", ovf, 4'b0000);
    clr = 1; wr(63, 8'h33); clr = 0;
    chk("s4_setwins", ovf, 4'b1000);
    ready = 1; repeat (4) step();
    ready = 0;
    wr(61, 8'h77);
    step();
    arm = 0; wr(60, 8'h5A);
    chk("s5_noarm", pending, 4'b0010);
    arm = 1; ready = 1; repeat (4) step();
    ready = 0;
    wr(60, 8'h40); wr(61, 8'h41); wr(62, 8'h42); wr(63, 8'h43);
    step();
    chk("s6_pend", pending, 4'b1111);
    rst_n = 0; step(); rst_n = 1;
    chk("s6_rst_valid", evt_valid, 1'b0);
    chk("s6_rst_pend", pending, 4'b0000);
    ready = 1;
    for (int i = 0; i < 24; i++) wr(6'(60 + i % 2), 8'(i));
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      we    = $urandom_range(0, 3) != 0;
      arm   = $urandom_range(0, 7) != 0;
      ready = $urandom_range(0, 2) != 0;
      clr   = $urandom_range(0, 15) == 0;
      adr   = $urandom_range(0, 1) ? 6'($urandom_range(60, 63)) : 6'($urandom);
      dat   = 8'($urandom);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
